// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared definitions for the multiply/divide unit: operation
//               encodings, default latencies and an op-class helper.
// Contents    : md_op_e           - 3-bit MD operation encoding
//               MD_MUL_CYCLES_DEF - default MULT/MULTU latency
//               MD_DIV_CYCLES_DEF - default DIV/DIVU latency
//               md_is_muldiv()    - true for the multi-cycle operations
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int MD_MUL_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF = 10;

    // Codes 0..3 occupy the unit for several cycles; 4/5 are single-cycle
    // register moves and 6/7 are reserved no-ops.
    function automatic logic md_is_muldiv(input logic [2:0] op);
        return (op <= MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_datapath.sv
`default_nettype none
// ============================================================================
// Module      : md_datapath
// Description : Combinational result generation for MULT/MULTU/DIV/DIVU from
//               the latched operands, including the divide-by-zero and
//               signed-overflow special cases.
// Ports       : op [2:0]  - latched operation code
//               a  [31:0] - latched rs operand (multiplicand / dividend)
//               b  [31:0] - latched rt operand (multiplier / divisor)
//               hi [31:0] - HI result (product high / remainder)
//               lo [31:0] - LO result (product low / quotient)
// Revision    : 1.0 - initial release
// ============================================================================
module md_datapath
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic        [31:0] w_divisor_s;
    logic        [31:0] w_divisor_u;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_quo_u;
    logic        [31:0] w_rem_u;

    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    assign w_div_zero = (b == 32'd0);
    assign w_div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // The dividers never see a zero divisor. For the signed overflow case a
    // divisor of 1 yields exactly the required quotient 0x80000000 and
    // remainder 0, so no separate result mux is needed for it.
    assign w_divisor_s = (w_div_zero || w_div_ovf) ? 32'd1 : b;
    assign w_divisor_u = w_div_zero ? 32'd1 : b;

    // SystemVerilog signed / truncates toward zero and % takes the sign of
    // the dividend, matching the required DIV semantics.
    assign w_quo_s = $signed(a) / $signed(w_divisor_s);
    assign w_rem_s = $signed(a) % $signed(w_divisor_s);
    assign w_quo_u = a / w_divisor_u;
    assign w_rem_u = a % w_divisor_u;

    always_comb begin
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            MD_MULT: begin
                hi = w_prod_s[63:32];
                lo = w_prod_s[31:0];
            end
            MD_MULTU: begin
                hi = w_prod_u[63:32];
                lo = w_prod_u[31:0];
            end
            MD_DIV: begin
                hi = w_div_zero ? a : w_rem_s;
                lo = w_div_zero ? 32'hFFFF_FFFF : w_quo_s;
            end
            MD_DIVU: begin
                hi = w_div_zero ? a : w_rem_u;
                lo = w_div_zero ? 32'hFFFF_FFFF : w_quo_u;
            end
            default: begin
                hi = 32'd0;
                lo = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : EX-stage multi-cycle multiply/divide unit owning HI/LO.
//               Runs MULT/MULTU/DIV/DIVU with fixed latency, MTHI/MTLO in one
//               cycle, and raises stall_md toward the hazard controller.
// Ports       : clk      - system clock, rising edge
//               reset    - asynchronous active-high reset
//               start    - EX instruction is an MD op
//               op [2:0] - MD operation code
//               A  [31:0]- forwarded rs operand
//               B  [31:0]- forwarded rt operand
//               md_use_D - instruction in D touches HI/LO
//               busy     - MUL/DIV in flight
//               stall_md - hold the HI/LO consumer in D
//               HI [31:0]- HI register
//               LO [31:0]- LO register
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = MD_MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int C_CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_MUL_LOAD = C_CNT_W'(MUL_CYCLES);
    localparam logic [C_CNT_W-1:0] C_DIV_LOAD = C_CNT_W'(DIV_CYCLES);

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [C_CNT_W-1:0] r_count;
    logic [2:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_load;
    logic               w_done;
    logic               w_mthi;
    logic               w_mtlo;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (start && md_is_muldiv(op)) begin
                    w_state_next = C_ST_BUSY;
                end
            end
            C_ST_BUSY: begin
                if (r_count == C_CNT_ONE) begin
                    w_state_next = C_ST_IDLE;
                end
            end
            default: w_state_next = C_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        busy   = 1'b0;
        w_load = 1'b0;
        w_done = 1'b0;
        w_mthi = 1'b0;
        w_mtlo = 1'b0;
        case (r_state)
            C_ST_IDLE: begin
                w_load = start && md_is_muldiv(op);
                w_mthi = start && (op == MD_MTHI);
                w_mtlo = start && (op == MD_MTLO);
            end
            C_ST_BUSY: begin
                busy   = 1'b1;
                w_done = (r_count == C_CNT_ONE);
            end
            default: busy = 1'b0;
        endcase
    end

    // The start-cycle term lets a HI/LO consumer directly behind a MUL/DIV
    // be held before busy has had a chance to rise.
    assign stall_md = md_use_D & (busy | (start & md_is_muldiv(op)));

    // ------------------------------------------------------------------
    // Latency counter and operand latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
        end else if (w_load) begin
            r_count <= op[1] ? C_DIV_LOAD : C_MUL_LOAD;
            r_op    <= op;
            r_a     <= A;
            r_b     <= B;
        end else if (busy) begin
            r_count <= r_count - C_CNT_ONE;
        end
    end

    md_datapath u_datapath (
        .op (r_op),
        .a  (r_a),
        .b  (r_b),
        .hi (w_res_hi),
        .lo (w_res_lo)
    );

    // ------------------------------------------------------------------
    // HI/LO registers: while busy only the completing op may write them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_done) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else begin
            if (w_mthi) begin
                r_hi <= A;
            end
            if (w_mtlo) begin
                r_lo <= A;
            end
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

    // The hazard controller must never issue an MD op while one is running.
    a_no_start_while_busy : assert property (
        @(posedge clk) disable iff (reset) !(busy && start)
    );

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit: directed cases plus random
//               operations compared against a behavioural HI/LO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] HI;
    logic [31:0] LO;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    always #5 clk = ~clk;

    md_unit #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .md_use_D (md_use_D),
        .busy     (busy),
        .stall_md (stall_md),
        .HI       (HI),
        .LO       (LO)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Behavioural HI/LO effect of one operation, straight from the ISA rules.
    task automatic ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb, sq;
        int unsigned     uq;
        case (o)
            3'd0: begin
                sa = a; sb = b;
                sp = longint'(sa) * longint'(sb);
                m_hi = sp[63:32]; m_lo = sp[31:0];
            end
            3'd1: begin
                up = 64'(a) * 64'(b);
                m_hi = up[63:32]; m_lo = up[31:0];
            end
            3'd2: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 32'd0;
                end else begin
                    sa = a; sb = b;
                    sq = sa / sb;
                    m_lo = sq;
                    m_hi = sa - sq * sb;
                end
            end
            3'd3: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else begin
                    uq = a / b;
                    m_lo = uq;
                    m_hi = a - uq * b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op, track busy/stall/hold each cycle, then check the result.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int   n, cyc;
        bit   stall_ok, hold_ok;
        logic use_d;
        n = (o <= 3'd1) ? MUL_N : (o <= 3'd3) ? DIV_N : 0;
        @(negedge clk);
        use_d    = 1'($urandom_range(0, 1));
        start    = 1'b1;
        op       = o;
        A        = a;
        B        = b;
        md_use_D = use_d;
        #1;
        chk("stall_start", 32'(stall_md), 32'(use_d & (o <= 3'd3)));
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        A     = $urandom;
        B     = $urandom;
        cyc      = 0;
        stall_ok = 1'b1;
        hold_ok  = 1'b1;
        while (busy === 1'b1 && cyc < 4 * DIV_N) begin
            cyc++;
            use_d    = 1'($urandom_range(0, 1));
            md_use_D = use_d;
            #1;
            if (stall_md !== use_d) stall_ok = 1'b0;
            if (HI !== m_hi || LO !== m_lo) hold_ok = 1'b0;
            @(negedge clk);
        end
        chk("latency", 32'(cyc), 32'(n));
        chk("stall_busy", 32'(stall_ok), 32'd1);
        chk("hilo_hold", 32'(hold_ok), 32'd1);
        ref_md(o, a, b);
        md_use_D = 1'b1;
        #1;
        chk("hi", HI, m_hi);
        chk("lo", LO, m_lo);
        chk("busy_done", 32'(busy), 32'd0);
        chk("stall_done", 32'(stall_md), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'd0;
        A        = 32'd0;
        B        = 32'd0;
        md_use_D = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_stall", 32'(stall_md), 32'd0);
        reset = 1'b0;

        // Directed cases with hand-derived results
        do_op(3'd0, 32'hFFFF_FFFD, 32'd7);
        chk("tp_mult_hi", HI, 32'hFFFF_FFFF);
        chk("tp_mult_lo", LO, 32'hFFFF_FFEB);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        chk("tp_multu_hi", HI, 32'd1);
        chk("tp_multu_lo", LO, 32'hFFFF_FFFE);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("tp_div_lo", LO, 32'hFFFF_FFFD);
        chk("tp_div_hi", HI, 32'hFFFF_FFFF);
        do_op(3'd3, 32'd7, 32'd0);
        chk("tp_divu0_lo", LO, 32'hFFFF_FFFF);
        chk("tp_divu0_hi", HI, 32'd7);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("tp_ovf_lo", LO, 32'h8000_0000);
        chk("tp_ovf_hi", HI, 32'd0);
        do_op(3'd2, 32'd9, 32'd0);
        chk("tp_div0_hi", HI, 32'd9);
        do_op(3'd6, 32'hDEAD_BEEF, 32'd1);
        do_op(3'd7, 32'hDEAD_BEEF, 32'd1);

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 32'h1234_5678; md_use_D = 1'b1;
        @(negedge clk);
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_busy", 32'(busy), 32'd0);
        op = 3'd5; A = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", LO, 32'h9ABC_DEF0);
        chk("mtlo_hi", HI, 32'h1234_5678);
        chk("mtlo_busy", 32'(busy), 32'd0);
        m_hi = 32'h1234_5678;
        m_lo = 32'h9ABC_DEF0;

        // Asynchronous reset in the middle of a MULT
        @(negedge clk);
        start = 1'b1; op = 3'd0; A = 32'd1234; B = 32'd5678; md_use_D = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (MUL_N + 3) @(negedge clk);
        chk("arst_after_hi", HI, 32'd0);
        chk("arst_after_lo", LO, 32'd0);
        chk("arst_after_busy", 32'(busy), 32'd0);
        do_op(3'd0, 32'd1234, 32'd5678);
        chk("post_rst_lo", LO, 32'd7006652);

        // Random operations against the model
        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom_range(0, 7)), pick(), pick());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
